param_serializer: RTL and testbench
===================================

# param_serializer

Parametrised, double-buffered parallel-to-serial converter for the UART TX path and other bit-serial links in the multi-clock system. It accepts words over a valid/ready handshake into a one-entry holding register, shifts them out one bit per `ser_en` strobe (the baud tick), LSB- or MSB-first, and can append a parity bit. Words stream back-to-back with no idle strobe between them, and `ser_done` pulses at the end of each word.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits; legal range is 2 or more.
- IDLE_LEVEL, 1'b1, value driven on `ser_data` at reset and while idle.

Ports:
- Clk  input  1  clock.
- RST  input  1  reset, asynchronous, active-low.
- p_data  input  DATA_WIDTH  parallel word.
- data_valid  input  1  `p_data` is valid.
- data_ready  output  1  holding register is empty.
- ser_en  input  1  advance strobe: one output bit per asserted cycle.
- msb_first  input  1  1 = MSB first, 0 = LSB first.
- par_en  input  1  append a parity bit after the data bits.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- ser_data  output  1  serial output, registered.
- ser_done  output  1  one-cycle pulse at the end of a word.
- busy  output  1  a word is in progress (`state != IDLE`).

## Operation
- Holding register:
  - Flag `hold_full`; `data_ready = ~hold_full`.
  - A transfer happens on a rising edge with `data_valid & data_ready`, which sets `hold_full`.
- State machine: IDLE, SHIFT, PARITY.
- **Load**:
  - Copy the holding register into the shift register and clear `hold_full`.
  - Latch `msb_first`, `par_en` and `par_typ` with the word. Later changes to these inputs do not affect the word in flight.
  - Compute the parity bit: `^data` for even, `~^data` for odd.
  - Set `count = 0`, state -> SHIFT.
- **IDLE**:
  - If `hold_full`, perform Load.
  - `ser_en` is ignored.
  - `ser_data` holds IDLE_LEVEL.
- **SHIFT**:
  - On `ser_en`, drive `ser_data` with bit `count` (LSB-first) or bit `DATA_WIDTH-1-count` (MSB-first), then increment `count`.
  - On the `ser_en` with `count == DATA_WIDTH-1`:
    - If parity is latched, state -> PARITY.
    - Otherwise, Finish.
- **PARITY**: on `ser_en`, drive the parity bit, then Finish.
- **Finish**:
  - Assert `ser_done` for one cycle.
  - If `hold_full`, perform Load on the same edge (state stays SHIFT).
  - Otherwise, state -> IDLE.
- Between strobes, `ser_data` holds the last driven bit. It returns to IDLE_LEVEL on the first cycle spent in IDLE.
- `count` width is `$clog2(DATA_WIDTH)`. The counter never wraps past DATA_WIDTH-1.
- Simultaneous events:
  - A new handshake on the Load/Finish edge is accepted, because `data_ready` reflects the pre-edge `hold_full`.
  - If the holding register empties and refills on the same edge, `hold_full` stays 1.
- Reset, including mid-word, aborts the word and empties the holding register. Values:
  - State IDLE, `count` 0.
  - `hold_full` 0, so `data_ready` 1.
  - `busy` 0, `ser_done` 0.
  - `ser_data` IDLE_LEVEL.

## Timing
- Handshake at edge N -> `hold_full` = 1 after N.
- From IDLE: Load at edge N+1, so `busy` = 1 and `data_ready` = 1 after N+1.
- The first bit appears on the edge of the first `ser_en` sampled in SHIFT (registered output). The earliest is edge N+2.
- A word takes exactly DATA_WIDTH (+1 with parity) `ser_en` strobes.
- `ser_done` rises on the same edge that drives the final bit and is high for exactly one Clk cycle.
- Back-to-back operation: the strobe after the final bit of word k drives bit 0 of word k+1, with zero idle strobes.
- `ser_en` may be asserted every cycle. Throughput is one bit per Clk.

## Test plan
- Reset check: hold reset, then release with no traffic -> `ser_data` = 1, `busy` = 0, `data_ready` = 1, `ser_done` = 0.
- LSB-first, no parity: DATA_WIDTH = 8, `p_data` = 8'hA5, `ser_en` every 4th cycle -> bits 1,0,1,0,0,1,0,1; one `ser_done` pulse on the 8th strobe.
- MSB-first with parity:
  - 8'hA5, even parity -> bits 1,0,1,0,0,1,0,1 then parity 0, with `ser_done` on the 9th strobe.
  - 8'h07, odd parity -> parity bit 0.
- Back-to-back streaming: 8'h0F, 8'hF0 and 8'h3C queued, `ser_en` held high -> 24 consecutive correct bits, `ser_done` every 8 cycles. `data_ready` drops while the holding register is full. No gap between words.
- Config change mid-word: toggle `msb_first` and `par_en` during a word -> the current word is unaffected and the next word uses the new settings.
- Mid-word reset: assert `RST` after 3 bits of 8'hFF with a word queued -> all outputs return to reset values and the queued word is discarded. A subsequent 8'h01 transmits correctly.

Source files
------------

// File: rtl/param_serializer_if.sv
// Parallel-word handshake and serial-output bundle for param_serializer.
interface param_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  ser_en;
  logic                  msb_first;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_data;
  logic                  ser_done;
  logic                  busy;

  modport master (
    output p_data, data_valid, ser_en, msb_first, par_en, par_typ,
    input  data_ready, ser_data, ser_done, busy
  );

  modport slave (
    input  p_data, data_valid, ser_en, msb_first, par_en, par_typ,
    output data_ready, ser_data, ser_done, busy
  );
endinterface

// File: rtl/param_serializer.sv
// Double-buffered parallel-to-serial converter: one-entry holding register in
// front of a shift stage, one bit per ser_en strobe, optional parity bit.
module param_serializer #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic               Clk,
  input logic               RST,
  param_serializer_if.slave ser_if
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  // Per-word settings captured at load so mid-word input changes are ignored.
  typedef struct packed {
    logic msb;
    logic par;
    logic pbit;
  } cfg_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  cfg_t                  cfg_q, cfg_d;
  logic                  sd_q, sd_d;
  logic                  done_q, done_d;

  logic                  accept, load, finish;
  logic [CW-1:0]         sel;

  // State register; reset aborts any word and empties the holding register.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cfg_q       <= '0;
      sd_q        <= IDLE_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cfg_q       <= cfg_d;
      sd_q        <= sd_d;
      done_q      <= done_d;
    end
  end

  // Next-state: shift/parity sequencing, load from holding register, handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cfg_d       = cfg_q;
    sd_d        = sd_q;
    done_d      = 1'b0;
    load        = 1'b0;
    finish      = 1'b0;
    // data_ready is the pre-edge ~hold_full, so a handshake coinciding with a
    // load/finish edge is still taken.
    accept      = ser_if.data_valid & ~hold_full_q;
    sel         = cfg_q.msb ? (LAST - cnt_q) : cnt_q;

    case (state_q)
      IDLE: begin
        sd_d = IDLE_LEVEL;
        load = hold_full_q;
      end
      SHIFT: begin
        if (ser_if.ser_en) begin
          sd_d = shreg_q[sel];
          if (cnt_q == LAST) begin
            if (cfg_q.par) state_d = PARITY;
            else           finish  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (ser_if.ser_en) begin
          sd_d   = cfg_q.pbit;
          finish = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Finishing a word chains straight into the next one when it is waiting.
    if (finish) begin
      done_d  = 1'b1;
      state_d = IDLE;
      load    = hold_full_q;
    end

    if (load) begin
      shreg_d = hold_q;
      cfg_d   = '{msb: ser_if.msb_first, par: ser_if.par_en,
                  pbit: ser_if.par_typ ? ~^hold_q : ^hold_q};
      cnt_d   = '0;
      state_d = SHIFT;
    end

    hold_full_d = (hold_full_q & ~load) | accept;
    if (accept) hold_d = ser_if.p_data;
  end

  assign ser_if.data_ready = ~hold_full_q;
  assign ser_if.ser_data   = sd_q;
  assign ser_if.ser_done   = done_q;
  assign ser_if.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_param_serializer.sv
// Self-checking bench: transaction-level model (bit queues per word) compared
// every cycle, plus directed bit-pattern checks and a randomized stream.
module tb_param_serializer;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic RST = 1'b0;
  always #5 Clk = ~Clk;

  param_serializer_if #(.DATA_WIDTH(W)) bus ();

  param_serializer #(.DATA_WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
    .Clk   (Clk),
    .RST   (RST),
    .ser_if(bus)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Stimulus state
  logic [W-1:0] tx_q[$];
  int  period = 1;
  bit  rand_cfg = 0;
  int  cyc = 0;

  // Reference model
  bit           m_hold;
  logic [W-1:0] m_hdata;
  bit           m_busy;
  bit           mq[$];
  bit           m_sd, m_done, m_strobed;

  // Observation
  bit obs[$];
  int done_cnt, first_s, last_s;

  function automatic void m_reset();
    m_hold = 0; m_hdata = '0; m_busy = 0; mq.delete();
    m_sd = 1; m_done = 0; m_strobed = 0;
  endfunction

  function automatic void m_load();
    for (int i = 0; i < W; i++)
      mq.push_back(bus.msb_first ? m_hdata[W-1-i] : m_hdata[i]);
    if (bus.par_en) mq.push_back((^m_hdata) ^ bus.par_typ);
    m_hold = 0;
    m_busy = 1;
  endfunction

  // One clock edge of the model, using the pre-edge inputs.
  function automatic void m_step();
    bit acc;
    if (!RST) begin m_reset(); return; end
    acc = bus.data_valid && !m_hold;
    m_done = 0; m_strobed = 0;
    if (!m_busy) begin
      m_sd = 1;
      if (m_hold) m_load();
    end else if (bus.ser_en) begin
      m_sd = mq.pop_front();
      m_strobed = 1;
      if (mq.size() == 0) begin
        m_done = 1;
        m_busy = 0;
        if (m_hold) m_load();
      end
    end
    if (acc) begin
      m_hold  = 1;
      m_hdata = bus.p_data;
      void'(tx_q.pop_front());
    end
  endfunction

  task automatic drive();
    cyc++;
    bus.ser_en     = (period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period) == 0);
    bus.data_valid = (tx_q.size() != 0);
    bus.p_data     = (tx_q.size() != 0) ? tx_q[0] : W'($urandom);
    if (rand_cfg) begin
      bus.msb_first = 1'($urandom_range(0, 1));
      bus.par_en    = 1'($urandom_range(0, 1));
      bus.par_typ   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    m_step();
    #1;
    chk("ser_data",   bus.ser_data,   m_sd);
    chk("ser_done",   bus.ser_done,   m_done);
    chk("busy",       bus.busy,       m_busy);
    chk("data_ready", bus.data_ready, !m_hold);
    if (m_strobed) begin
      obs.push_back(bus.ser_data);
      if (first_s < 0) first_s = cyc;
      last_s = cyc;
    end
    if (bus.ser_done) done_cnt++;
    drive();
  endtask

  task automatic clr_obs();
    obs.delete(); done_cnt = 0; first_s = -1; last_s = -1;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((m_busy || m_hold || tx_q.size() != 0) && k < max) begin tick(); k++; end
    if (k >= max) chk("drain_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic wait_bits(input int n);
    int k = 0;
    while (obs.size() < n && k < 500) begin tick(); k++; end
    if (k >= 500) chk("wait_bits_timeout", 0, 1);
  endtask

  function automatic logic [31:0] pack_lsb(input int from, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) if (from + i < obs.size()) r[i] = obs[from+i];
    return r;
  endfunction

  function automatic logic [31:0] pack_msb(input int from, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], (from + i < obs.size()) ? obs[from+i] : 1'b0};
    return r;
  endfunction

  initial begin
    bus.p_data = '0; bus.data_valid = 0; bus.ser_en = 0;
    bus.msb_first = 0; bus.par_en = 0; bus.par_typ = 0;
    m_reset(); clr_obs();

    // Reset state, during and after reset
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ser_data", bus.ser_data, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.data_ready, 1'b1);
    chk("rst_done", bus.ser_done, 1'b0);
    RST = 1'b1;
    repeat (4) tick();

    // LSB-first, no parity, strobe every 4th cycle
    period = 4; bus.msb_first = 0; bus.par_en = 0;
    clr_obs(); tx_q.push_back(8'hA5); drain(400);
    chk("a5_lsb_nbits", obs.size(), 8);
    chk("a5_lsb_bits", pack_lsb(0, 8), 32'hA5);
    chk("a5_lsb_done", done_cnt, 1);

    // MSB-first, even parity
    bus.msb_first = 1; bus.par_en = 1; bus.par_typ = 0;
    clr_obs(); tx_q.push_back(8'hA5); drain(400);
    chk("a5_msb_par_nbits", obs.size(), 9);
    chk("a5_msb_par_bits", pack_msb(0, 9), 32'b1_0100_1010);
    chk("a5_msb_par_done", done_cnt, 1);

    // MSB-first, odd parity of 0x07 is 0
    bus.par_typ = 1;
    clr_obs(); tx_q.push_back(8'h07); drain(400);
    chk("07_odd_nbits", obs.size(), 9);
    chk("07_odd_bits", pack_msb(0, 8), 32'h07);
    chk("07_odd_parity", obs.size() > 8 ? obs[8] : 1'bx, 1'b0);

    // Back-to-back, ser_en every cycle
    period = 1; bus.msb_first = 0; bus.par_en = 0;
    clr_obs();
    tx_q.push_back(8'h0F); tx_q.push_back(8'hF0); tx_q.push_back(8'h3C);
    drain(400);
    chk("b2b_nbits", obs.size(), 24);
    chk("b2b_bits", pack_lsb(0, 24), 32'h003CF00F);
    chk("b2b_done", done_cnt, 3);
    chk("b2b_no_gap", last_s - first_s + 1, 24);

    // Config change mid-word: first word LSB/no parity, second MSB/even parity
    period = 2; bus.msb_first = 0; bus.par_en = 0; bus.par_typ = 0;
    clr_obs();
    tx_q.push_back(8'h35); tx_q.push_back(8'hC6);
    wait_bits(2);
    bus.msb_first = 1; bus.par_en = 1;
    drain(400);
    chk("cfg_nbits", obs.size(), 17);
    chk("cfg_word1", pack_lsb(0, 8), 32'h35);
    chk("cfg_word2", pack_msb(8, 8), 32'hC6);
    chk("cfg_parity", obs.size() > 16 ? obs[16] : 1'bx, 1'b0);

    // Mid-word reset with a word held
    period = 3; bus.msb_first = 0; bus.par_en = 0;
    clr_obs();
    tx_q.push_back(8'hFF); tx_q.push_back(8'hAA);
    wait_bits(3);
    chk("mrst_held", bus.data_ready, 1'b0);
    RST = 1'b0; m_reset(); tx_q.delete();
    bus.data_valid = 0;
    #1;
    chk("mrst_ser_data", bus.ser_data, 1'b1);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_ready", bus.data_ready, 1'b1);
    chk("mrst_done", bus.ser_done, 1'b0);
    repeat (2) tick();
    RST = 1'b1;
    repeat (6) tick();
    clr_obs(); tx_q.push_back(8'h01); drain(400);
    chk("post_rst_nbits", obs.size(), 8);
    chk("post_rst_bits", pack_lsb(0, 8), 32'h01);

    // Randomized stream with random strobes and per-cycle config churn
    period = 0; rand_cfg = 1;
    for (int i = 0; i < 40; i++) tx_q.push_back(W'($urandom));
    drain(3000);
    rand_cfg = 0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
